// File: rtl/sr_deser.sv
// Serial-in, parallel-out frame receiver with start-bit framing, selectable bit order,
// a valid/ready output stage, and overrun / frame-restart pulses.
module sr_deser #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  output logic             frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic             order;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] sr_first;
  logic             out_free;

  // The start bit is shifted into a cleared register, which leaves it in the end bit
  // matching the order that is being latched.
  always_comb begin
    sr_shift = order ? {sin, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sin};
    sr_first = '0;
    if (lsb_first) sr_first[WIDTH-1] = sin;
    else           sr_first[0]       = sin;
    out_free = !dout_valid || dout_ready;
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      order      <= 1'b0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      if (sin_valid && sin_start) begin
        // A start always opens a new frame; when one was already open, that frame is lost.
        if (state == SHIFT) frame_err <= 1'b1;
        sr      <= sr_first;
        order   <= lsb_first;
        bit_cnt <= CW'(1);
        state   <= SHIFT;
      end else if (sin_valid && state == SHIFT) begin
        sr <= sr_shift;
        if (bit_cnt == LAST_CNT) begin
          state   <= IDLE;
          bit_cnt <= '0;
          if (out_free) begin
            dout       <= sr_shift;
            dout_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sr_deser.sv
// Self-checking bench for sr_deser: directed scenarios plus a randomized run, all judged
// against a frame-level reference model that rebuilds each word from the received bit list.
module tb_sr_deser;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sin = 1'b0;
  logic          sin_valid = 1'b0;
  logic          sin_start = 1'b0;
  logic          lsb_first = 1'b0;
  logic          dout_ready = 1'b0;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;
  logic          frame_err;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: the bits collected so far for the open frame and the output port.
  bit     m_bits[$];
  bit     m_active;
  bit     m_lsb;
  bit [W-1:0] m_dout;
  bit     m_dv;
  bit     m_ovr;
  bit     m_ferr;

  sr_deser #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .lsb_first(lsb_first), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .bit_cnt(bit_cnt), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] m_cnt();
    return m_active ? CW'(m_bits.size()) : '0;
  endfunction

  function automatic logic [W-1:0] assemble(input bit lsb);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb) w = w | (W'(m_bits[i]) << i);
      else     w = (w << 1) | W'(m_bits[i]);
    end
    return w;
  endfunction

  task automatic model_reset();
    m_bits = {};
    m_active = 0; m_lsb = 0; m_dout = '0; m_dv = 0; m_ovr = 0; m_ferr = 0;
  endtask

  task automatic model_edge(input bit v, input bit s, input bit b, input bit l, input bit r);
    bit free = !m_dv || r;
    m_ovr = 0;
    m_ferr = 0;
    if (m_dv && r) m_dv = 0;
    if (v && s) begin
      if (m_active) m_ferr = 1;
      m_bits = {b};
      m_lsb = l;
      m_active = 1;
    end else if (v && m_active) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        if (free) begin
          m_dout = assemble(m_lsb);
          m_dv = 1;
        end else begin
          m_ovr = 1;
        end
        m_bits = {};
        m_active = 0;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge,
  // and leave the caller 1 time unit past that edge for sampling.
  task automatic step(input bit v, input bit s, input bit b, input bit l, input bit r);
    @(negedge clk);
    sin_valid = v; sin_start = s; sin = b; lsb_first = l; dout_ready = r;
    @(posedge clk);
    model_edge(v, s, b, l, r);
    #1;
  endtask

  function automatic bit word_bit(input logic [W-1:0] w, input bit lsb, input int i);
    return lsb ? w[i] : w[W-1-i];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #3;
    vectors++;
    if ({dout, dout_valid, busy, bit_cnt, overrun, frame_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got dout=%h dv=%b busy=%b cnt=%0d ovr=%b ferr=%b, want all 0",
               dout, dout_valid, busy, bit_cnt, overrun, frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_msb_basic();
    logic [W-1:0] w = 8'h01;
    for (int i = 0; i < W; i++) begin
      step(1, i == 0, word_bit(w, 0, i), 0, 1);
      vectors++;
      if ({dout, dout_valid, busy, bit_cnt, overrun, frame_err} !== {m_dout, m_dv, m_active, m_cnt(), m_ovr, m_ferr}) begin
        errors++;
        $display("[TB] FAIL msb_basic: got dout=%h dv=%b busy=%b cnt=%0d, want dout=%h dv=%b busy=%b cnt=%0d",
                 dout, dout_valid, busy, bit_cnt, m_dout, m_dv, m_active, m_cnt());
      end
    end
    vectors++;
    if (dout !== 8'h01 || dout_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL msb_word: got dout=%h dv=%b, want dout=01 dv=1", dout, dout_valid);
    end
    step(0, 0, 0, 0, 1);
    vectors++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL msb_one_cycle_valid: got dv=%b, want 0", dout_valid);
    end
  endtask

  task automatic test_lsb_order();
    logic [W-1:0] w = 8'hA6;
    // Bit stream 0,0,0,0,0,0,0,1 with LSB-first latched, then lsb_first dropped mid-frame.
    for (int i = 0; i < W; i++) step(1, i == 0, i == W - 1, i == 0, 1);
    vectors++;
    if (dout !== 8'h80 || dout_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lsb_word: got dout=%h dv=%b, want dout=80 dv=1", dout, dout_valid);
    end
    for (int i = 0; i < W; i++) begin
      repeat (3) step(0, 0, 1, 1, 1);
      step(1, i == 0, word_bit(w, 0, i), 0, 1);
      vectors++;
      if (bit_cnt !== CW'((i + 1) % W) || busy !== (i != W - 1)) begin
        errors++;
        $display("[TB] FAIL gap_bit_cnt: got cnt=%0d busy=%b, want cnt=%0d busy=%b",
                 bit_cnt, busy, (i + 1) % W, i != W - 1);
      end
    end
    vectors++;
    if (dout !== 8'hA6 || dout_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL gap_word: got dout=%h dv=%b, want dout=a6 dv=1", dout, dout_valid);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_overrun();
    logic [W-1:0] w [2] = '{8'h5A, 8'hC3};
    int pulses = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < W; i++) begin
        step(1, i == 0, word_bit(w[f], 0, i), 0, 0);
        if (overrun) pulses++;
      end
    vectors++;
    if (dout !== 8'h5A || dout_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_keep: got dout=%h dv=%b ovr=%b, want dout=5a dv=1 ovr=1", dout, dout_valid, overrun);
    end
    step(0, 0, 0, 0, 1);
    if (overrun) pulses++;
    vectors++;
    if (pulses != 1 || dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_pulse: got pulses=%0d dv=%b, want pulses=1 dv=0", pulses, dout_valid);
    end
  endtask

  task automatic test_ready_on_last();
    logic [W-1:0] w [2] = '{8'h11, 8'h22};
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < W; i++) step(1, i == 0, word_bit(w[f], 0, i), 0, f == 1 && i == W - 1);
    vectors++;
    if (dout !== 8'h22 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_on_last: got dout=%h dv=%b ovr=%b, want dout=22 dv=1 ovr=0", dout, dout_valid, overrun);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_restart();
    logic [W-1:0] w = 8'hF0;
    int ferr_pulses = 0;
    for (int i = 0; i < 5; i++) step(1, i == 0, 1, 0, 1);
    for (int i = 0; i < W; i++) begin
      step(1, i == 0, word_bit(w, 0, i), 0, 1);
      if (frame_err) ferr_pulses++;
      vectors++;
      if ({dout, dout_valid, busy, bit_cnt, frame_err} !== {m_dout, m_dv, m_active, m_cnt(), m_ferr}) begin
        errors++;
        $display("[TB] FAIL restart_cycle: got dout=%h dv=%b cnt=%0d ferr=%b, want dout=%h dv=%b cnt=%0d ferr=%b",
                 dout, dout_valid, bit_cnt, frame_err, m_dout, m_dv, m_cnt(), m_ferr);
      end
    end
    vectors++;
    if (dout !== 8'hF0 || ferr_pulses != 1) begin
      errors++;
      $display("[TB] FAIL restart_word: got dout=%h ferr_pulses=%0d, want dout=f0 ferr_pulses=1", dout, ferr_pulses);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    logic [W-1:0] w = 8'h81;
    for (int i = 0; i < W; i++) step(1, i == 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, i == 0, 1, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({dout, dout_valid, busy, bit_cnt, overrun, frame_err} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got dout=%h dv=%b busy=%b cnt=%0d, want all 0", dout, dout_valid, busy, bit_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W; i++) step(1, i == 0, word_bit(w, 1, i), 1, 1);
    vectors++;
    if (dout !== 8'h81 || dout_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_word: got dout=%h dv=%b, want dout=81 dv=1", dout, dout_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      bit v = $urandom_range(0, 3) != 0;
      bit s = v && (m_active ? $urandom_range(0, 24) == 0 : $urandom_range(0, 2) == 0);
      step(v, s, 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
      vectors++;
      if ({dout, dout_valid, busy, bit_cnt, overrun, frame_err} !== {m_dout, m_dv, m_active, m_cnt(), m_ovr, m_ferr}) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got dout=%h dv=%b busy=%b cnt=%0d ovr=%b ferr=%b, want dout=%h dv=%b busy=%b cnt=%0d ovr=%b ferr=%b",
                 n, dout, dout_valid, busy, bit_cnt, overrun, frame_err, m_dout, m_dv, m_active, m_cnt(), m_ovr, m_ferr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_basic();
    test_lsb_order();
    test_overrun();
    test_ready_on_last();
    test_restart();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
